// File: rtl/ct_ebiu_ncwt_table.sv
// ct_ebiu_ncwt_table
//   Tracks outstanding non-cacheable / strongly-ordered writes issued from the
//   NC queue. Each entry follows write-data completion, the bus B response and
//   the return of the response to the issuing PIU. Responses leave through one
//   round-robin channel. Younger reads and writes probe the table for
//   address-index dependencies.
//
// Ports
//   forever_cpuclk                : free-running clock
//   cpurst                        : asynchronous active-high reset
//   create_vld/awaddr/awid/needissue, create_rdy/create_ptr : allocation
//   wdata_done_vld/ptr            : all write data of an entry has been sent
//   bus_bresp_vld/ptr, bus_bresp  : B response popped for an entry
//   resp_vld/rdy/id/bresp/piu_sel : response channel to the PIUs
//   wr_dep_awaddr/rd_dep_araddr, wr_dep_hit/rd_dep_hit : dependency probes
//   ncwt_cnt, ncwt_empty          : occupancy

module gated_clk_cell (
    input  logic clk_in,
    input  logic local_en,
    output logic clk_out
);
    // Enable is captured while the clock is low so clk_out cannot glitch.
    logic en_lat;

    always_latch begin
        if (!clk_in) en_lat <= local_en;
    end

    assign clk_out = clk_in & en_lat;
endmodule

module ct_ebiu_ncwt_table #(
    parameter int         ENTRY    = 8,
    parameter int         PTRW     = 3,
    parameter int         ADDRW    = 40,
    parameter int         IDX_LSB  = 6,
    parameter int         IDX_MSB  = 13,
    parameter logic [4:0] WO_EX_ID = 5'b11110
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             create_vld,
    input  logic [ADDRW-1:0] create_awaddr,
    input  logic [7:0]       create_awid,
    input  logic             create_needissue,
    output logic             create_rdy,
    output logic [PTRW-1:0]  create_ptr,
    input  logic             wdata_done_vld,
    input  logic [PTRW-1:0]  wdata_done_ptr,
    input  logic             bus_bresp_vld,
    input  logic [PTRW-1:0]  bus_bresp_ptr,
    input  logic [1:0]       bus_bresp,
    output logic             resp_vld,
    input  logic             resp_rdy,
    output logic [7:0]       resp_id,
    output logic [1:0]       resp_bresp,
    output logic [3:0]       resp_piu_sel,
    input  logic [ADDRW-1:0] wr_dep_awaddr,
    input  logic [ADDRW-1:0] rd_dep_araddr,
    output logic             wr_dep_hit,
    output logic             rd_dep_hit,
    output logic [PTRW:0]    ncwt_cnt,
    output logic             ncwt_empty
);
    localparam int IDXW = IDX_MSB - IDX_LSB + 1;

    logic [ENTRY-1:0]            vld, vld_nxt, resp_ready, resp_done, bus_done;
    logic [ENTRY-1:0]            create_en, gm_fail, lock, req, pop;
    logic [ENTRY-1:0][1:0]       ent_bresp;
    logic [ENTRY-1:0][7:0]       ent_id;
    logic [ENTRY-1:0][IDXW-1:0]  ent_idx;
    logic [PTRW-1:0]             rr_ptr, rr_sel, hold_ptr, sel_ptr;
    logic                        hold, rr_found, free_found, create_fire, create_lock, resp_hs;
    logic [7:0]                  sel_id;
    logic                        unused_addr_bits;

    assign unused_addr_bits = ^{create_awaddr, wr_dep_awaddr, rd_dep_araddr};

    always_comb begin
        free_found = 1'b0;
        create_ptr = '0;
        for (int i = 0; i < ENTRY; i++) begin
            if (!vld[i] && !free_found) begin
                free_found = 1'b1;
                create_ptr = PTRW'(i);
            end
        end
    end

    assign create_rdy  = ~&vld;
    assign create_fire = create_vld & create_rdy;
    assign create_lock = (create_awid[4:0] == WO_EX_ID);

    // Per-entry datapath: written only at allocation, so it sits on a gated clock.
    for (genvar gi = 0; gi < ENTRY; gi++) begin : g_ent
        logic            ent_clk;
        logic [7:0]      id_q;
        logic [IDXW-1:0] idx_q;
        logic            gm_q, lock_q;

        assign create_en[gi] = create_fire && (create_ptr == PTRW'(gi));

        gated_clk_cell u_gclk (
            .clk_in   (forever_cpuclk),
            .local_en (create_en[gi]),
            .clk_out  (ent_clk)
        );

        always_ff @(posedge ent_clk or posedge cpurst) begin
            if (cpurst) begin
                id_q   <= '0;
                idx_q  <= '0;
                gm_q   <= 1'b0;
                lock_q <= 1'b0;
            end else begin
                id_q   <= create_awid;
                idx_q  <= create_awaddr[IDX_MSB:IDX_LSB];
                gm_q   <= !create_needissue;
                lock_q <= create_lock;
            end
        end

        assign ent_id[gi]  = id_q;
        assign ent_idx[gi] = idx_q;
        assign gm_fail[gi] = gm_q;
        assign lock[gi]    = lock_q;
    end

    assign req     = vld & resp_ready & ~resp_done;
    assign pop     = vld & resp_done & bus_done;
    assign vld_nxt = (vld & ~pop) | create_en;

    always_comb begin
        int j;
        j        = 0;
        rr_found = 1'b0;
        rr_sel   = '0;
        for (int k = 0; k < ENTRY; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= ENTRY) j = j - ENTRY;
            if (!rr_found && req[j]) begin
                rr_found = 1'b1;
                rr_sel   = PTRW'(j);
            end
        end
    end

    // A stalled response keeps its entry so a newly ready one cannot preempt it.
    assign sel_ptr  = hold ? hold_ptr : rr_sel;
    assign resp_vld = |req;
    assign resp_hs  = resp_vld & resp_rdy;
    assign sel_id   = ent_id[sel_ptr];

    assign resp_id      = resp_vld ? sel_id : 8'h00;
    assign resp_bresp   = resp_vld ? ent_bresp[sel_ptr] : 2'b00;
    assign resp_piu_sel = !resp_vld ? 4'b0000 :
                          sel_id[7] ? 4'b1111 : 4'(4'b0001 << sel_id[6:5]);

    always_comb begin
        wr_dep_hit = 1'b0;
        rd_dep_hit = 1'b0;
        for (int i = 0; i < ENTRY; i++) begin
            if (vld[i] && ent_idx[i] == wr_dep_awaddr[IDX_MSB:IDX_LSB]) wr_dep_hit = 1'b1;
            if (vld[i] && ent_idx[i] == rd_dep_araddr[IDX_MSB:IDX_LSB]) rd_dep_hit = 1'b1;
        end
    end

    function automatic logic [PTRW:0] popcnt(input logic [ENTRY-1:0] v);
        logic [PTRW:0] s;
        s = '0;
        for (int i = 0; i < ENTRY; i++) s = s + {{PTRW{1'b0}}, v[i]};
        return s;
    endfunction

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            vld        <= '0;
            resp_ready <= '0;
            resp_done  <= '0;
            bus_done   <= '0;
            ent_bresp  <= '0;
            rr_ptr     <= '0;
            hold       <= 1'b0;
            hold_ptr   <= '0;
            ncwt_cnt   <= '0;
        end else begin
            vld      <= vld_nxt;
            ncwt_cnt <= popcnt(vld_nxt);
            for (int i = 0; i < ENTRY; i++) begin
                if (create_en[i]) begin
                    resp_ready[i] <= 1'b0;
                    resp_done[i]  <= 1'b0;
                    bus_done[i]   <= create_lock & !create_needissue;
                    ent_bresp[i]  <= 2'b00;
                end else if (vld[i]) begin
                    // Lock writes that did reach the bus wait for their B response.
                    if ((wdata_done_vld && wdata_done_ptr == PTRW'(i) && (!lock[i] || gm_fail[i])) ||
                        (bus_bresp_vld && bus_bresp_ptr == PTRW'(i)))
                        resp_ready[i] <= 1'b1;
                    if (bus_bresp_vld && bus_bresp_ptr == PTRW'(i)) begin
                        bus_done[i]  <= 1'b1;
                        ent_bresp[i] <= bus_bresp;
                    end
                    if (resp_hs && sel_ptr == PTRW'(i)) resp_done[i] <= 1'b1;
                end
            end
            if (resp_hs) begin
                rr_ptr <= (sel_ptr == PTRW'(ENTRY - 1)) ? '0 : sel_ptr + 1'b1;
                hold   <= 1'b0;
            end else begin
                hold     <= resp_vld;
                hold_ptr <= sel_ptr;
            end
        end
    end

    assign ncwt_empty = ~|vld;
endmodule

// File: tb/tb_ct_ebiu_ncwt_table.sv
module tb_ct_ebiu_ncwt_table;
    logic        forever_cpuclk, cpurst;
    logic        create_vld, create_needissue, create_rdy;
    logic [39:0] create_awaddr, wr_dep_awaddr, rd_dep_araddr;
    logic [7:0]  create_awid, resp_id;
    logic [2:0]  create_ptr, wdata_done_ptr, bus_bresp_ptr;
    logic        wdata_done_vld, bus_bresp_vld, resp_vld, resp_rdy;
    logic [1:0]  bus_bresp, resp_bresp;
    logic [3:0]  resp_piu_sel, ncwt_cnt;
    logic        wr_dep_hit, rd_dep_hit, ncwt_empty;

    int checks = 0;
    int errors = 0;

    ct_ebiu_ncwt_table dut (
        .forever_cpuclk(forever_cpuclk), .cpurst(cpurst),
        .create_vld(create_vld), .create_awaddr(create_awaddr), .create_awid(create_awid),
        .create_needissue(create_needissue), .create_rdy(create_rdy), .create_ptr(create_ptr),
        .wdata_done_vld(wdata_done_vld), .wdata_done_ptr(wdata_done_ptr),
        .bus_bresp_vld(bus_bresp_vld), .bus_bresp_ptr(bus_bresp_ptr), .bus_bresp(bus_bresp),
        .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_id(resp_id), .resp_bresp(resp_bresp),
        .resp_piu_sel(resp_piu_sel), .wr_dep_awaddr(wr_dep_awaddr), .rd_dep_araddr(rd_dep_araddr),
        .wr_dep_hit(wr_dep_hit), .rd_dep_hit(rd_dep_hit), .ncwt_cnt(ncwt_cnt), .ncwt_empty(ncwt_empty)
    );

    initial begin
        forever_cpuclk = 1'b0;
        forever #5 forever_cpuclk = ~forever_cpuclk;
    end

    // Reference model: the life of each outstanding write as a record.
    typedef struct {
        bit         v, lock, gm, dat, bus, rdy, ret;
        logic [7:0] id, idx;
        logic [1:0] br;
    } ent_t;
    ent_t m[8];
    int   rr, held;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = '{default: 0};
        rr   = 0;
        held = -1;
    endtask

    function automatic int pick_sel();
        if (held >= 0) return held;
        for (int k = 0; k < 8; k++) begin
            int j = (rr + k) % 8;
            if (m[j].v && m[j].rdy && !m[j].ret) return j;
        end
        return -1;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < 8; i++) if (!m[i].v) return i;
        return -1;
    endfunction

    function automatic int count_valid();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m[i].v ? 1 : 0;
        return n;
    endfunction

    function automatic logic hit_of(input logic [39:0] a);
        for (int i = 0; i < 8; i++) if (m[i].v && m[i].idx == a[13:6]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] piu_of(input logic [7:0] id);
        return id[7] ? 4'hF : 4'(1 << id[6:5]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sel = pick_sel();
        int fr  = first_free();
        logic [7:0] eid = (sel >= 0) ? m[sel].id : 8'h00;
        chk("create_rdy", 32'(create_rdy), 32'(fr >= 0));
        chk("create_ptr", 32'(create_ptr), (fr >= 0) ? fr : 0);
        chk("resp_vld", 32'(resp_vld), 32'(sel >= 0));
        chk("resp_id", 32'(resp_id), 32'(eid));
        chk("resp_bresp", 32'(resp_bresp), (sel >= 0) ? 32'(m[sel].br) : 0);
        chk("resp_piu_sel", 32'(resp_piu_sel), (sel >= 0) ? 32'(piu_of(eid)) : 0);
        chk("wr_dep_hit", 32'(wr_dep_hit), 32'(hit_of(wr_dep_awaddr)));
        chk("rd_dep_hit", 32'(rd_dep_hit), 32'(hit_of(rd_dep_araddr)));
        chk("ncwt_cnt", 32'(ncwt_cnt), count_valid());
        chk("ncwt_empty", 32'(ncwt_empty), 32'(count_valid() == 0));
    endtask

    task automatic model_step();
        int sel = pick_sel();
        bit hs  = (sel >= 0) && resp_rdy;
        int fr  = first_free();
        bit popnow[8];
        for (int i = 0; i < 8; i++) popnow[i] = m[i].v && m[i].ret && m[i].bus;
        for (int i = 0; i < 8; i++) begin
            if (!m[i].v) continue;
            if (wdata_done_vld && int'(wdata_done_ptr) == i) begin
                m[i].dat = 1;
                if (!m[i].lock || m[i].gm) m[i].rdy = 1;
            end
            if (bus_bresp_vld && int'(bus_bresp_ptr) == i) begin
                m[i].rdy = 1;
                m[i].bus = 1;
                m[i].br  = bus_bresp;
            end
            if (hs && sel == i) m[i].ret = 1;
            if (popnow[i]) m[i].v = 0;
        end
        if (hs) rr = (sel + 1) % 8;
        held = (sel >= 0 && !hs) ? sel : -1;
        if (create_vld && fr >= 0) begin
            m[fr]      = '{default: 0};
            m[fr].v    = 1;
            m[fr].id   = create_awid;
            m[fr].idx  = create_awaddr[13:6];
            m[fr].lock = (create_awid[4:0] == 5'b11110);
            m[fr].gm   = !create_needissue;
            m[fr].bus  = m[fr].lock && m[fr].gm;
        end
    endtask

    task automatic cycle();
        @(negedge forever_cpuclk);
        check_all();
        model_step();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic idle();
        create_vld = 0; create_awaddr = '0; create_awid = '0; create_needissue = 1;
        wdata_done_vld = 0; wdata_done_ptr = '0;
        bus_bresp_vld = 0; bus_bresp_ptr = '0; bus_bresp = '0;
        resp_rdy = 0;
    endtask

    task automatic do_create(input logic [7:0] id, input logic [7:0] idx, input bit ni);
        create_vld = 1; create_awid = id; create_awaddr = 40'(idx) << 6; create_needissue = ni;
        cycle(); idle();
    endtask

    task automatic do_wdata(input int p);
        wdata_done_vld = 1; wdata_done_ptr = 3'(p);
        cycle(); idle();
    endtask

    task automatic do_bresp(input int p, input logic [1:0] br);
        bus_bresp_vld = 1; bus_bresp_ptr = 3'(p); bus_bresp = br;
        cycle(); idle();
    endtask

    task automatic pulse_reset();
        cpurst = 1;
        #1;
        model_reset();
        #2;
        cpurst = 0;
    endtask

    initial begin
        int ord[3] = '{0, 3, 7};
        int q[$];
        cpurst = 1;
        idle();
        wr_dep_awaddr = '0;
        rd_dep_araddr = '0;
        model_reset();
        repeat (2) @(posedge forever_cpuclk);
        #1;
        cpurst = 0;

        chk("rst_create_rdy", 32'(create_rdy), 1);
        chk("rst_resp_vld", 32'(resp_vld), 0);
        chk("rst_cnt", 32'(ncwt_cnt), 0);
        chk("rst_empty", 32'(ncwt_empty), 1);

        // Early response for a plain write, then the bus response frees it.
        do_create(8'h21, 8'hA5, 1);
        chk("cnt_one", 32'(ncwt_cnt), 1);
        rd_dep_araddr = 40'(8'hA5) << 6;
        #1 chk("rd_hit_a5", 32'(rd_dep_hit), 1);
        rd_dep_araddr = 40'(8'hA4) << 6;
        #1 chk("rd_hit_a4", 32'(rd_dep_hit), 0);
        rd_dep_araddr = 40'(8'hA5) << 6;
        do_wdata(0);
        chk("p1_resp_vld", 32'(resp_vld), 1);
        chk("p1_resp_id", 32'(resp_id), 32'h21);
        chk("p1_piu_sel", 32'(resp_piu_sel), 32'b0010);
        resp_rdy = 1; cycle(); idle();
        do_bresp(0, 2'b10);
        cycle();
        chk("p1_empty", 32'(ncwt_empty), 1);
        chk("rd_hit_after_pop", 32'(rd_dep_hit), 0);

        // Lock write that failed the global monitor: no bus response needed.
        do_create(8'h1E, 8'h10, 0);
        do_wdata(0);
        chk("p2_resp_vld", 32'(resp_vld), 1);
        chk("p2_resp_bresp", 32'(resp_bresp), 0);
        resp_rdy = 1; cycle(); idle();
        chk("p2_cnt_hs", 32'(ncwt_cnt), 1);
        cycle();
        chk("p2_empty", 32'(ncwt_empty), 1);

        // Lock write issued to the bus waits for its B response.
        do_create(8'h3E, 8'h11, 1);
        do_wdata(0);
        chk("p3_no_resp", 32'(resp_vld), 0);
        cycle();
        chk("p3_no_resp2", 32'(resp_vld), 0);
        do_bresp(0, 2'b01);
        chk("p3_resp_vld", 32'(resp_vld), 1);
        chk("p3_resp_bresp", 32'(resp_bresp), 32'b01);
        chk("p3_piu_sel", 32'(resp_piu_sel), 32'b0010);
        resp_rdy = 1; cycle(); idle();
        cycle();
        chk("p3_empty", 32'(ncwt_empty), 1);

        // Fill, round-robin order, no preemption of a stalled response, reuse.
        pulse_reset();
        for (int i = 0; i < 8; i++) do_create(8'h40 + 8'(i), 8'(i), 1);
        chk("full_rdy", 32'(create_rdy), 0);
        chk("full_cnt", 32'(ncwt_cnt), 8);
        create_vld = 1; create_awid = 8'h77; cycle(); idle();
        do_wdata(0); do_wdata(3); do_wdata(7);
        resp_rdy = 1;
        for (int k = 0; k < 3; k++) begin
            chk("rr_order", 32'(resp_id), 32'h40 + ord[k]);
            cycle();
        end
        idle();
        do_wdata(5);
        cycle();
        do_wdata(1);
        chk("hold_id", 32'(resp_id), 32'h45);
        resp_rdy = 1;
        cycle();
        chk("after_hold_id", 32'(resp_id), 32'h41);
        cycle(); idle();
        do_bresp(5, 2'b10);
        cycle();
        chk("reuse_ptr", 32'(create_ptr), 5);
        chk("reuse_cnt", 32'(ncwt_cnt), 7);

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            create_vld       = ($urandom_range(0, 2) != 0);
            create_awid      = 8'($urandom);
            if ($urandom_range(0, 3) == 0) create_awid[4:0] = 5'b11110;
            create_needissue = ($urandom_range(0, 3) != 0);
            create_awaddr    = 40'({$urandom, $urandom});
            create_awaddr[13:6] = 8'hA0 + 8'($urandom_range(0, 3));
            wr_dep_awaddr    = 40'(8'hA0 + 8'($urandom_range(0, 4))) << 6;
            rd_dep_araddr    = 40'(8'hA0 + 8'($urandom_range(0, 4))) << 6;
            q.delete();
            for (int i = 0; i < 8; i++) if (m[i].v && !m[i].dat) q.push_back(i);
            wdata_done_vld = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            wdata_done_ptr = (q.size() > 0) ? 3'(q[$urandom_range(0, q.size() - 1)]) : 3'd0;
            q.delete();
            for (int i = 0; i < 8; i++) if (m[i].v && !m[i].bus) q.push_back(i);
            bus_bresp_vld = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            bus_bresp_ptr = (q.size() > 0) ? 3'(q[$urandom_range(0, q.size() - 1)]) : 3'd0;
            bus_bresp     = 2'($urandom);
            resp_rdy      = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Asynchronous reset in the middle of traffic discards everything at once.
        idle();
        cpurst = 1;
        #1;
        chk("midrst_resp_vld", 32'(resp_vld), 0);
        chk("midrst_cnt", 32'(ncwt_cnt), 0);
        chk("midrst_empty", 32'(ncwt_empty), 1);
        model_reset();
        #2 cpurst = 0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
